// File: rtl/nibble_packer_pkg.sv
// Shared types and widths for the nibble-to-byte reassembly path.
package nibble_packer_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_LOW,
        ST_HIGH
    } pack_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       partial;
    } pack_entry_t;

    localparam int ENTRY_W = $bits(pack_entry_t);

    function automatic pack_entry_t makeEntry(
        input logic [BYTE_W-1:0] data,
        input logic              last,
        input logic              partial
    );
        pack_entry_t entry;
        entry.data    = data;
        entry.last    = last;
        entry.partial = partial;
        return entry;
    endfunction

endpackage

// File: rtl/nibble_packer_fifo.sv
// Two-entry synchronous FIFO holding assembled bytes; the head is read
// straight out of storage so downstream never sees a combinational input path.
module nibble_packer_fifo
    import nibble_packer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_entry,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_head,
    output logic               o_full,
    output logic               o_empty,
    output logic [1:0]         o_count
);

    pack_entry_t r_mem [2];
    logic        r_wrPtr;
    logic        r_rdPtr;
    logic [1:0]  r_count;

    logic w_doPush;
    logic w_doPop;

    assign o_full   = (r_count == 2'(DEPTH));
    assign o_empty  = (r_count == 2'd0);
    assign o_count  = r_count;
    assign o_head   = r_mem[r_rdPtr];

    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;

    // Storage is cleared on reset so the head reads as all zeros while empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wrPtr  <= 1'b0;
        end else if (w_doPush) begin
            r_mem[r_wrPtr] <= pack_entry_t'(i_entry);
            r_wrPtr        <= ~r_wrPtr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdPtr <= 1'b0;
        end else if (w_doPop) begin
            r_rdPtr <= ~r_rdPtr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 2'd0;
        end else begin
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nibble_packer.sv
// Reassembles a low-nibble-first stream into bytes; a last marker on a lone
// low nibble flushes it as a zero-padded partial byte.
module nibble_packer
    import nibble_packer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              nib_valid,
    output logic              nib_ready,
    input  logic [NIB_W-1:0]  nib_data,
    input  logic              nib_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_last,
    output logic              out_partial
);

    pack_state_t      r_state;
    pack_state_t      w_nextState;
    logic [NIB_W-1:0] r_loQ;
    logic [NIB_W-1:0] w_nextLoQ;

    logic               w_accept;
    logic               w_push;
    pack_entry_t        w_pushEntry;
    logic [ENTRY_W-1:0] w_headBits;
    pack_entry_t        w_head;
    logic               w_full;
    logic               w_empty;
    logic [1:0]         w_count;

    // Readiness depends only on registered occupancy, never on out_ready.
    assign nib_ready = rst_n && (w_count != 2'(DEPTH));
    assign w_accept  = nib_valid && nib_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_LOW;
            r_loQ   <= '0;
        end else begin
            r_state <= w_nextState;
            r_loQ   <= w_nextLoQ;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextLoQ   = r_loQ;
        w_push      = 1'b0;
        w_pushEntry = '0;
        if (w_accept) begin
            case (r_state)
                ST_LOW: begin
                    if (nib_last) begin
                        w_push      = 1'b1;
                        w_pushEntry = makeEntry({4'h0, nib_data}, 1'b1, 1'b1);
                    end else begin
                        w_nextLoQ   = nib_data;
                        w_nextState = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    w_push      = 1'b1;
                    w_pushEntry = makeEntry({nib_data, r_loQ}, nib_last, 1'b0);
                    w_nextState = ST_LOW;
                end
                default: begin
                    w_nextState = ST_LOW;
                end
            endcase
        end
    end

    nibble_packer_fifo #(
        .DEPTH (DEPTH)
    ) uFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push && !w_full),
        .i_entry (w_pushEntry),
        .i_pop   (out_ready),
        .o_head  (w_headBits),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head      = pack_entry_t'(w_headBits);
    assign out_valid   = !w_empty;
    assign out_data    = w_head.data;
    assign out_last    = w_head.last;
    assign out_partial = w_head.partial;

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Receive-side counterpart of the byte-splitting datapath: accepts a stream of 4-bit nibbles over a valid/ready handshake and reassembles them into 8-bit bytes, low nibble first. Completed bytes are buffered in a 2-entry output FIFO with their own valid/ready handshake, so upstream sees backpressure only when the FIFO is full. A `nib_last` marker flushes a pending half-byte as a zero-padded partial byte, closing a packet on any nibble boundary.

## Interface
- `DEPTH`, 2: output FIFO entries; fixed at 2, other values unsupported
- `clk`  input  1  sole clock, rising edge
- `rst_n`  input  1  synchronous, active-low reset
- `nib_valid`  input  1  upstream nibble valid
- `nib_ready`  output  1  nibble accepted when `nib_valid && nib_ready` at a rising edge
- `nib_data`  input  4  nibble payload
- `nib_last`  input  1  final nibble of packet; qualified by `nib_valid`
- `out_valid`  output  1  FIFO head valid
- `out_ready`  input  1  downstream takes head when `out_valid && out_ready`
- `out_data`  output  8  assembled byte, `{high, low}`
- `out_last`  output  1  byte carries end of packet
- `out_partial`  output  1  byte was flushed after low nibble only; `out_data[7:4]` = 0

## Operation
- Two-state FSM with states LOW and HIGH. LOW waits for the low nibble; HIGH holds the low nibble in `lo_q`.
- LOW, accept, `nib_last=0`: store `lo_q <= nib_data`, go to HIGH, no push.
- LOW, accept, `nib_last=1`: push `{4'h0, nib_data}` with last=1 and partial=1, stay in LOW.
- HIGH, accept: push `{nib_data, lo_q}` with last=`nib_last` and partial=0, go to LOW.
- `nib_ready = rst_n && (count != DEPTH)`. The FIFO is never written when full, so no push is ever dropped.
- Pop: `out_valid && out_ready` removes the head. A push and a pop in the same cycle are both honoured and leave `count` unchanged. When full, a pop in cycle N raises `nib_ready` in cycle N+1, not N.
- FIFO is first-in first-out. `count` ranges 0..2.
- Read and write pointers are 1 bit each and wrap from 1 to 0.
- No combinational path from `out_ready` to `nib_ready`.
- `out_data`, `out_last` and `out_partial` hold stable while `out_valid && !out_ready`.

## Timing
- Reset (`rst_n` sampled low): FSM goes to LOW, `lo_q`=0, `count`=0, pointers=0.
- Output values during and after reset: `out_valid`=0, `out_data`=8'h00, `out_last`=0, `out_partial`=0.
- `nib_ready` is 0 combinationally while `rst_n`=0, and 1 on the first cycle after release.
- Reset mid-byte: the held low nibble and all FIFO contents are discarded, with no partial flush.
- Latency: from the accepting edge of the completing nibble (HIGH accept, or LOW with last) to `out_valid`=1 is one cycle.
- Throughput: one byte per 2 accepted nibbles. Full rate is sustained with `out_ready` held at 1.
- `out_*` are driven from FIFO storage registers through a read mux on the read pointer; no input-to-output combinational path.

## Structure
- Package `nibble_packer_pkg` holds:
  - `NIB_W`=4 and `BYTE_W`=8
  - `typedef enum logic {ST_LOW, ST_HIGH} pack_state_t`
  - `typedef struct packed {logic [7:0] data; logic last; logic partial;} pack_entry_t`
- Sub-module `nibble_packer_fifo`: 2-entry synchronous FIFO of `pack_entry_t` with push/pop, full/empty, `count` and `rst_n`.
- Top level contains the FSM, `lo_q` and the push-entry formation.

## Test plan
- Reset, then nibbles 4'h5, 4'hA with `out_ready`=1 → one cycle after the second accept, `out_valid`=1, `out_data`=8'hA5, `out_last`=0, `out_partial`=0.
- Packet 4'h3 (last=0), 4'hC (last=1), 4'h7 (last=1) → bytes 8'hC3 (last=1, partial=0) then 8'h07 (last=1, partial=1).
- `out_ready`=0, stream 6 nibbles 1..6 → `nib_ready` drops after the 4th accept (count=2) and nibbles 5..6 stall. Then raise `out_ready` → 8'h21, 8'h43, 8'h65 in order, none lost.
- Count=1, simultaneous pop and push on the same edge → `count` stays 1, `nib_ready` stays 1, order is preserved.
- Continuous nibbles with `out_ready`=1 for 64 nibbles 0..F repeating → 32 bytes, each `{n+1, n}`. Pointers wrap repeatedly with no stall after the first byte.
- Assert `rst_n`=0 while in HIGH holding 4'h9 with one entry queued → `out_valid`=0, `nib_ready`=0. After release, nibbles 4'h1, 4'h2 produce 8'h21 only, with no trace of 4'h9.
